mult_wb_buffer: RTL and testbench
=================================

# mult_wb_buffer

Writeback buffer and arbiter directly downstream of the pipelined multiplier manager. It accepts the multiplier's final-stage result (valid, destination register, 32-bit data) and merges it with the main pipeline's writeback onto the register file's single write port. The main pipeline has priority; multiplier results that lose arbitration are held in a small FIFO. The block also provides issue back-pressure and an optional operand-forwarding lookup.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `HEADROOM`, `` `MULT_PPL_STAGE ``: results that may still be in flight in the multiplier when issue stalls.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `mult_valid_i`  in  1  multiplier final-stage result valid.
- `mult_rd_addr_i`  in  5  multiplier destination register.
- `mult_data_i`  in  32  multiplier result.
- `pipe_we_i`  in  1  main-pipeline writeback enable.
- `pipe_rd_addr_i`  in  5  main-pipeline destination register.
- `pipe_rd_data_i`  in  32  main-pipeline data.
- `rf_we_o`  out  1  register-file write enable (combinational).
- `rf_waddr_o`  out  5  register-file write address.
- `rf_wdata_o`  out  32  register-file write data.
- `stall_o`  out  1  registered; high when `count + HEADROOM >= DEPTH`.
- `level_o`  out  clog2(DEPTH+1)  FIFO occupancy.
- `overflow_o`  out  1  sticky error: a push was attempted while the FIFO was full.
- `fwd_addr_i`  in  5  forwarding lookup address.
- `fwd_hit_o`  out  1  a pending multiplier result exists for `fwd_addr_i`.
- `fwd_data_o`  out  32  newest pending data for that address.

## Operation
- **Effective inputs.** A write with destination register 0 is treated as absent. This applies to both pipe and mult sources.
- **Arbitration.** One port winner per cycle, in this priority order:
  1. Pipe write.
  2. FIFO head (pop).
  3. Direct bypass of `mult_*` when the FIFO is empty.
- **Pop.** A head entry pops whenever the pipe is idle. A squashed head pops with `rf_we_o=0`, so it consumes the cycle but writes nothing.
- **Push.** The incoming mult result is pushed at the tail when it does not win the port. This happens when:
  - the pipe is writing, or
  - the FIFO is non-empty (which preserves ordering).
- **Simultaneous events.** Pop and push in the same cycle are legal; the level is unchanged. The FIFO uses wrap-around pointers with one extra pointer bit.
- **Full.** A push into a full FIFO is dropped and sets `overflow_o`. `overflow_o` clears only on `rst`.
- **WAW squash.** A pipe write is younger than every buffered or arriving mult result.
  - On a pipe write to register R, every valid FIFO entry with address R is marked squashed.
  - A same-cycle arriving mult result to R is not pushed at all.
- **Forwarding.** Combinational search of unsquashed pending results, newest first:
  1. The arriving mult result, if it is not written this cycle.
  2. FIFO entries from tail to head.
  - Register 0 never hits.
  - A result being written to the register file this cycle does not hit; the register-file bypass covers it.

## Timing
- **Reset values.**
  - `rf_we_o=0`, `rf_waddr_o=0`, `rf_wdata_o=0` while `rst` is high.
  - `stall_o=0`, `level_o=0`, `overflow_o=0`; all entries cleared.
- **Reset mid-operation.** Buffered results are discarded. The issue stage must treat reset as a flush.
- **Latency.**
  - Bypass path: zero cycles, mult input to `rf_*` in the same cycle.
  - Pushed entry: earliest write is the cycle after the push.
- **Stall timing.** `stall_o` reflects the post-edge level, so it is valid one cycle after the push. `HEADROOM` absorbs the in-flight results, so a correctly stalled issue stage never overflows.
- **Throughput.** One register-file write per cycle.

## Configuration
- **`MULT_WB_FWD_EN` defined:** the forwarding search logic is compiled in.
- **`MULT_WB_FWD_EN` undefined:**
  - The search logic is compiled out.
  - `fwd_hit_o=0` and `fwd_data_o=0` constantly.
  - `fwd_addr_i` is ignored.
  - The issue stage must then stall on any pending mult destination.

## Test plan
- **Bypass.** Idle pipe, empty FIFO; mult valid, r5=0x1234 → same cycle: `rf_we_o=1`, addr 5, data 0x1234; `level_o` stays 0.
- **Contention.**
  - Stimulus: pipe writes r3=0xA for 3 consecutive cycles while mult delivers r7=1, r8=2, r9=3 in those cycles.
  - Response: `level_o` goes 1, 2, 3. Then r7, r8, r9 are written in order on the next 3 idle cycles, and `level_o` returns to 0.
- **Squash.**
  - Stimulus: FIFO holds r4=0x11, then the pipe writes r4=0x22 → entry squashed.
  - Response: on the next idle cycle the pop has `rf_we_o=0`. r4 ends at 0x22. The forward lookup of r4 misses after the squash.
- **Full/overflow.**
  - `DEPTH`=4, `HEADROOM`=2: `stall_o` rises after the 2nd push.
  - A 5th push while full with the pipe busy → dropped and `overflow_o=1`, held until `rst`.
- **Forwarding priority.** FIFO holds r6=0x1 then r6=0x2, and mult arrives r6=0x3 while the pipe is busy → `fwd_hit_o=1`, `fwd_data_o=0x3`; `fwd_addr_i`=0 → no hit.
- **Async reset mid-burst.** Assert `rst` between clock edges with `level_o`=3 → outputs and level go to 0 immediately. Writes resume correctly after deassertion.

Source files
------------

// File: rtl/mult_wb_buffer.sv
// rtl/mult_wb_buffer.sv - multiplier writeback buffer and register-file write-port arbiter
// Define MULT_WB_FWD_EN to compile in the operand-forwarding search.
`ifndef MULT_PPL_STAGE
`define MULT_PPL_STAGE 2
`endif

module mult_wb_buffer #(
   parameter int DEPTH    = 4,
   parameter int HEADROOM = `MULT_PPL_STAGE
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mult_valid_i,
   input  logic [4:0]                 mult_rd_addr_i,
   input  logic [31:0]                mult_data_i,
   input  logic                       pipe_we_i,
   input  logic [4:0]                 pipe_rd_addr_i,
   input  logic [31:0]                pipe_rd_data_i,
   output logic                       rf_we_o,
   output logic [4:0]                 rf_waddr_o,
   output logic [31:0]                rf_wdata_o,
   output logic                       stall_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o,
   output logic                       overflow_o,
   input  logic [4:0]                 fwd_addr_i,
   output logic                       fwd_hit_o,
   output logic [31:0]                fwd_data_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int LW = $clog2(DEPTH + 1);

   logic [4:0]       ent_addr [DEPTH];
   logic [31:0]      ent_data [DEPTH];
   logic [DEPTH-1:0] ent_sq;
   logic [PW-1:0]    wr_ptr, rd_ptr, count, count_next;
   logic [AW-1:0]    head_idx, tail_idx;
   logic             pipe_eff, mult_eff, empty, full;
   logic             pop, pop_write, push_req, push, bypass;

   assign pipe_eff   = pipe_we_i && (pipe_rd_addr_i != 5'd0);
   assign mult_eff   = mult_valid_i && (mult_rd_addr_i != 5'd0);
   assign count      = wr_ptr - rd_ptr;
   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (count == PW'(DEPTH));
   assign head_idx   = rd_ptr[AW-1:0];
   assign tail_idx   = wr_ptr[AW-1:0];
   assign pop        = !pipe_eff && !empty;
   assign pop_write  = pop && !ent_sq[head_idx];
   assign bypass     = !pipe_eff && empty && mult_eff;
   // A mult result to the register the pipe is writing is already dead.
   assign push_req   = mult_eff && !bypass &&
                       !(pipe_eff && (mult_rd_addr_i == pipe_rd_addr_i));
   assign push       = push_req && (!full || pop);
   assign count_next = count + PW'(push) - PW'(pop);
   assign level_o    = LW'(count);

   always_comb begin
      rf_we_o    = 1'b0;
      rf_waddr_o = '0;
      rf_wdata_o = '0;
      if (!rst) begin
         if (pipe_eff) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = pipe_rd_addr_i;
            rf_wdata_o = pipe_rd_data_i;
         end else if (pop_write) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = ent_addr[head_idx];
            rf_wdata_o = ent_data[head_idx];
         end else if (bypass) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = mult_rd_addr_i;
            rf_wdata_o = mult_data_i;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         ent_sq     <= '0;
         stall_o    <= 1'b0;
         overflow_o <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_addr[i] <= '0;
            ent_data[i] <= '0;
         end
      end else begin
         // Stale slots may get marked too; a push always rewrites its flag.
         if (pipe_eff) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (ent_addr[i] == pipe_rd_addr_i)
                  ent_sq[i] <= 1'b1;
            end
         end
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (push) begin
            ent_addr[tail_idx] <= mult_rd_addr_i;
            ent_data[tail_idx] <= mult_data_i;
            ent_sq[tail_idx]   <= 1'b0;
            wr_ptr             <= wr_ptr + PW'(1);
         end
         if (push_req && full && !pop)
            overflow_o <= 1'b1;
         stall_o <= (int'(count_next) + HEADROOM >= DEPTH);
      end
   end

`ifdef MULT_WB_FWD_EN
   // Head to tail with later matches overriding, then the arriving result on top.
   always_comb begin
      fwd_hit_o  = 1'b0;
      fwd_data_o = '0;
      if ((fwd_addr_i != 5'd0) && !(pipe_eff && (fwd_addr_i == pipe_rd_addr_i))) begin
         for (int k = 0; k < DEPTH; k++) begin
            if ((PW'(k) < count) && !((k == 0) && pop_write) &&
                !ent_sq[head_idx + AW'(k)] &&
                (ent_addr[head_idx + AW'(k)] == fwd_addr_i)) begin
               fwd_hit_o  = 1'b1;
               fwd_data_o = ent_data[head_idx + AW'(k)];
            end
         end
         if (push_req && (mult_rd_addr_i == fwd_addr_i)) begin
            fwd_hit_o  = 1'b1;
            fwd_data_o = mult_data_i;
         end
      end
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^fwd_addr_i;
   assign fwd_hit_o  = 1'b0;
   assign fwd_data_o = '0;
`endif

endmodule

// File: tb/tb_mult_wb_buffer.sv
// tb/tb_mult_wb_buffer.sv - table-driven and randomized check of mult_wb_buffer against a queue model
module tb_mult_wb_buffer;
   localparam int DEPTH    = 4;
   localparam int HEADROOM = 2;
`ifdef MULT_WB_FWD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        mult_valid, pipe_we;
   logic [4:0]  mult_rd_addr, pipe_rd_addr, fwd_addr;
   logic [31:0] mult_data, pipe_rd_data;
   logic        rf_we, stall, overflow, fwd_hit;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata, fwd_data;
   logic [2:0]  level;

   always #5 clk = ~clk;

   mult_wb_buffer #(.DEPTH(DEPTH), .HEADROOM(HEADROOM)) dut (
      .clk(clk), .rst(rst),
      .mult_valid_i(mult_valid), .mult_rd_addr_i(mult_rd_addr), .mult_data_i(mult_data),
      .pipe_we_i(pipe_we), .pipe_rd_addr_i(pipe_rd_addr), .pipe_rd_data_i(pipe_rd_data),
      .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
      .stall_o(stall), .level_o(level), .overflow_o(overflow),
      .fwd_addr_i(fwd_addr), .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data)
   );

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      bit          sq;
   } ent_t;

   typedef struct {
      bit pv; logic [4:0] pa; logic [31:0] pd;
      bit mv; logic [4:0] ma; logic [31:0] md;
      logic [4:0] fa;
      bit we; logic [4:0] wa; logic [31:0] wd;
      int lvl; bit stl; bit ovf; bit hit; logic [31:0] fd;
   } vec_t;

   ent_t q[$];
   vec_t vt[$];
   bit   m_ovf, m_stall;
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit pv, input logic [4:0] pa, input logic [31:0] pd,
                        input bit mv, input logic [4:0] ma, input logic [31:0] md,
                        input logic [4:0] fa);
      pipe_we = pv; pipe_rd_addr = pa; pipe_rd_data = pd;
      mult_valid = mv; mult_rd_addr = ma; mult_data = md;
      fwd_addr = fa;
   endtask

   task automatic add(input bit pv, input logic [4:0] pa, input logic [31:0] pd,
                      input bit mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic [4:0] fa, input bit we, input logic [4:0] wa,
                      input logic [31:0] wd, input int lvl, input bit stl, input bit ovf,
                      input bit hit, input logic [31:0] fd);
      vec_t r;
      r.pv = pv; r.pa = pa; r.pd = pd; r.mv = mv; r.ma = ma; r.md = md; r.fa = fa;
      r.we = we; r.wa = wa; r.wd = wd; r.lvl = lvl; r.stl = stl; r.ovf = ovf;
      r.hit = hit; r.fd = fd;
      vt.push_back(r);
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf   = 1'b0;
      m_stall = 1'b0;
   endtask

   // Compares the settled outputs of this cycle with the model, then advances it past the edge.
   task automatic model_step();
      bit pe, me, pop, push, ewe, ehit;
      logic [4:0]  ea;
      logic [31:0] ed, efd;
      pe = pipe_we && (pipe_rd_addr != 0);
      me = mult_valid && (mult_rd_addr != 0);
      pop = 0; push = 0; ewe = 0; ea = 0; ed = 0;
      if (pe) begin
         ewe = 1; ea = pipe_rd_addr; ed = pipe_rd_data;
         push = me && (mult_rd_addr != pipe_rd_addr);
      end else if (q.size() > 0) begin
         pop = 1; ewe = !q[0].sq; ea = q[0].addr; ed = q[0].data;
         push = me;
      end else if (me) begin
         ewe = 1; ea = mult_rd_addr; ed = mult_data;
      end
      ehit = 0; efd = 0;
      if (fwd_addr != 0 && !(pe && fwd_addr == pipe_rd_addr)) begin
         if (push && mult_rd_addr == fwd_addr) begin
            ehit = 1; efd = mult_data;
         end else begin
            for (int i = q.size() - 1; i >= 0; i--) begin
               if (!(i == 0 && pop && ewe) && !q[i].sq && q[i].addr == fwd_addr) begin
                  ehit = 1; efd = q[i].data;
                  break;
               end
            end
         end
      end
      if (!FWD_EN) begin
         ehit = 0; efd = 0;
      end
      chk("m_rf_we", 32'(rf_we), 32'(ewe));
      if (ewe) begin
         chk("m_rf_waddr", 32'(rf_waddr), 32'(ea));
         chk("m_rf_wdata", rf_wdata, ed);
      end
      chk("m_level", 32'(level), 32'(q.size()));
      chk("m_stall", 32'(stall), 32'(m_stall));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_fwd_hit", 32'(fwd_hit), 32'(ehit));
      if (ehit)
         chk("m_fwd_data", fwd_data, efd);
      if (pe)
         foreach (q[i]) if (q[i].addr == pipe_rd_addr) q[i].sq = 1;
      if (pop)
         void'(q.pop_front());
      if (push) begin
         if (q.size() >= DEPTH) m_ovf = 1;
         else begin
            ent_t e;
            e.addr = mult_rd_addr; e.data = mult_data; e.sq = 0;
            q.push_back(e);
         end
      end
      m_stall = (q.size() + HEADROOM >= DEPTH);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      model_reset();

      //   pv pa  pd      mv ma  md        fa  we wa  wd       lvl stl ovf hit fd
      add(0, 0, 0,      1, 5,  32'h1234, 0,  1, 5,  32'h1234, 0, 0, 0, 0, 0);
      add(1, 3, 32'hA,  1, 7,  1,        0,  1, 3,  32'hA,    0, 0, 0, 0, 0);
      add(1, 3, 32'hA,  1, 8,  2,        0,  1, 3,  32'hA,    1, 0, 0, 0, 0);
      add(1, 3, 32'hA,  1, 9,  3,        0,  1, 3,  32'hA,    2, 1, 0, 0, 0);
      add(0, 0, 0,      0, 0,  0,        0,  1, 7,  1,        3, 1, 0, 0, 0);
      add(0, 0, 0,      0, 0,  0,        0,  1, 8,  2,        2, 1, 0, 0, 0);
      add(0, 0, 0,      0, 0,  0,        0,  1, 9,  3,        1, 0, 0, 0, 0);
      add(0, 0, 0,      0, 0,  0,        0,  0, 0,  0,        0, 0, 0, 0, 0);
      add(1, 1, 32'h55, 1, 4,  32'h11,   0,  1, 1,  32'h55,   0, 0, 0, 0, 0);
      add(1, 4, 32'h22, 0, 0,  0,        4,  1, 4,  32'h22,   1, 0, 0, 0, 0);
      add(0, 0, 0,      0, 0,  0,        4,  0, 0,  0,        1, 0, 0, 0, 0);
      add(0, 0, 0,      0, 0,  0,        0,  0, 0,  0,        0, 0, 0, 0, 0);
      add(1, 2, 7,      1, 6,  1,        0,  1, 2,  7,        0, 0, 0, 0, 0);
      add(1, 2, 7,      1, 6,  2,        0,  1, 2,  7,        1, 0, 0, 0, 0);
      add(1, 2, 7,      1, 6,  3,        6,  1, 2,  7,        2, 1, 0, 1, 3);
      add(0, 0, 0,      0, 0,  0,        6,  1, 6,  1,        3, 1, 0, 1, 3);
      add(0, 0, 0,      0, 0,  0,        0,  1, 6,  2,        2, 1, 0, 0, 0);
      add(0, 0, 0,      0, 0,  0,        6,  1, 6,  3,        1, 0, 0, 0, 0);
      add(0, 0, 0,      0, 0,  0,        0,  0, 0,  0,        0, 0, 0, 0, 0);
      add(1, 1, 9,      1, 10, 32'h10,   0,  1, 1,  9,        0, 0, 0, 0, 0);
      add(1, 1, 9,      1, 11, 32'h11,   0,  1, 1,  9,        1, 0, 0, 0, 0);
      add(1, 1, 9,      1, 12, 32'h12,   0,  1, 1,  9,        2, 1, 0, 0, 0);
      add(1, 1, 9,      1, 13, 32'h13,   0,  1, 1,  9,        3, 1, 0, 0, 0);
      add(1, 1, 9,      1, 14, 32'h14,   0,  1, 1,  9,        4, 1, 0, 0, 0);
      add(1, 1, 9,      0, 0,  0,        0,  1, 1,  9,        4, 1, 1, 0, 0);
      add(0, 0, 0,      0, 0,  0,        0,  1, 10, 32'h10,   4, 1, 1, 0, 0);

      #1;
      chk("rst_rf_we", 32'(rf_we), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_fwd_hit", 32'(fwd_hit), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i].pv, vt[i].pa, vt[i].pd, vt[i].mv, vt[i].ma, vt[i].md, vt[i].fa);
         #1;
         chk($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(vt[i].we));
         if (vt[i].we) begin
            chk($sformatf("v%0d_rf_waddr", i), 32'(rf_waddr), 32'(vt[i].wa));
            chk($sformatf("v%0d_rf_wdata", i), rf_wdata, vt[i].wd);
         end
         chk($sformatf("v%0d_level", i), 32'(level), 32'(vt[i].lvl));
         chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vt[i].stl));
         chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vt[i].ovf));
         chk($sformatf("v%0d_fwd_hit", i), 32'(fwd_hit), 32'(FWD_EN && vt[i].hit));
         if (FWD_EN && vt[i].hit)
            chk($sformatf("v%0d_fwd_data", i), fwd_data, vt[i].fd);
         model_step();
      end

      // Asynchronous reset between edges with three results still buffered.
      drive(0, 0, 0, 1, 5'd20, 32'hBEEF, 0);
      #2;
      chk("pre_reset_level", 32'(level), 3);
      rst = 1'b1;
      #1;
      chk("arst_rf_we", 32'(rf_we), 0);
      chk("arst_rf_waddr", 32'(rf_waddr), 0);
      chk("arst_rf_wdata", rf_wdata, 0);
      chk("arst_level", 32'(level), 0);
      chk("arst_stall", 32'(stall), 0);
      chk("arst_overflow", 32'(overflow), 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      drive(0, 0, 0, 1, 5'd5, 32'h1234, 0);
      #1;
      chk("post_rst_bypass_we", 32'(rf_we), 1);
      chk("post_rst_bypass_data", rf_wdata, 32'h1234);
      model_step();

      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 9) < 5, 5'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 7)));
         #1;
         model_step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
